// File: rtl/vx_dispatch_lane_packer.sv
// Per-unit lane packer: round-robin picks an issue slot and splits its
// NUM_THREADS-wide operands into NUM_LANES-wide packets, skipping empty batches.
module vx_dispatch_lane_packer #(
  parameter int unsigned ISSUE_WIDTH = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HDRW        = 64,
  localparam int unsigned NPKT = NUM_THREADS / NUM_LANES,
  localparam int unsigned PIDW = (NPKT > 1) ? $clog2(NPKT) : 1,
  localparam int unsigned ISW  = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [ISSUE_WIDTH-1:0]               in_valid,
  output logic [ISSUE_WIDTH-1:0]               in_ready,
  input  logic [ISSUE_WIDTH*HDRW-1:0]          in_hdr,
  input  logic [ISSUE_WIDTH*NUM_THREADS-1:0]   in_tmask,
  input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs1,
  input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs2,
  input  logic [ISSUE_WIDTH*NUM_THREADS*XLEN-1:0] in_rs3,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [HDRW-1:0]                      out_hdr,
  output logic [NUM_LANES-1:0]                 out_tmask,
  output logic [NUM_LANES*XLEN-1:0]            out_rs1,
  output logic [NUM_LANES*XLEN-1:0]            out_rs2,
  output logic [NUM_LANES*XLEN-1:0]            out_rs3,
  output logic [PIDW-1:0]                      out_pid,
  output logic                                 out_sop,
  output logic                                 out_eop,
  output logic [ISW-1:0]                       out_isw
);

  localparam int unsigned TW = NUM_THREADS * XLEN;
  localparam int unsigned LW = NUM_LANES * XLEN;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [ISW-1:0]    sel_q, sel_d;
  logic [ISW-1:0]    rr_q, rr_d;
  logic [PIDW-1:0]   batch_q, batch_d;

  logic                    valid_q;
  logic [HDRW-1:0]         hdr_q;
  logic [NUM_LANES-1:0]    tmask_q;
  logic [LW-1:0]           rs1_q, rs2_q, rs3_q;
  logic [PIDW-1:0]         pid_q;
  logic                    sop_q, eop_q;
  logic [ISW-1:0]          isw_q;

  logic [ISW-1:0]          sel, idx;
  logic                    cand;
  logic [PIDW-1:0]         cur;
  logic                    found, more, last;
  logic                    adv, fire;

  logic [HDRW-1:0]         slot_hdr;
  logic [NUM_THREADS-1:0]  slot_tm;
  logic [TW-1:0]           slot_rs1, slot_rs2, slot_rs3;
  logic [NUM_LANES-1:0]    lane_tm;
  logic [LW-1:0]           lane_rs1, lane_rs2, lane_rs3;

  // Slot selection: the locked slot wins, otherwise scan upward from rr_q with wrap.
  always_comb begin
    sel  = sel_q;
    cand = 1'b0;
    idx  = '0;
    if (state_q == ST_LOCKED) begin
      cand = in_valid[sel_q];
    end else begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
        idx = ISW'((32'(rr_q) + i) % ISSUE_WIDTH);
        if (!cand && in_valid[idx]) begin
          cand = 1'b1;
          sel  = idx;
        end
      end
    end
  end

  assign slot_hdr = in_hdr[sel*HDRW +: HDRW];
  assign slot_tm  = in_tmask[sel*NUM_THREADS +: NUM_THREADS];
  assign slot_rs1 = in_rs1[sel*TW +: TW];
  assign slot_rs2 = in_rs2[sel*TW +: TW];
  assign slot_rs3 = in_rs3[sel*TW +: TW];

  // First non-empty batch at or above batch_q; an all-zero mask falls back to batch 0 as last.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    cur   = '0;
    for (int unsigned b = 0; b < NPKT; b++) begin
      if (b >= 32'(batch_q) && (|slot_tm[b*NUM_LANES +: NUM_LANES])) begin
        if (!found) begin
          found = 1'b1;
          cur   = PIDW'(b);
        end else begin
          more = 1'b1;
        end
      end
    end
    last = !more;
  end

  assign lane_tm  = slot_tm[cur*NUM_LANES +: NUM_LANES];
  assign lane_rs1 = slot_rs1[cur*LW +: LW];
  assign lane_rs2 = slot_rs2[cur*LW +: LW];
  assign lane_rs3 = slot_rs3[cur*LW +: LW];

  assign adv  = !valid_q || out_ready;
  assign fire = reset && adv && cand;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    batch_d  = batch_q;
    in_ready = '0;
    if (fire) begin
      if (last) begin
        in_ready = ISSUE_WIDTH'(1) << sel;
        state_d  = ST_OPEN;
        batch_d  = '0;
        rr_d     = ISW'((32'(sel) + 1) % ISSUE_WIDTH);
      end else begin
        state_d  = ST_LOCKED;
        sel_d    = sel;
        batch_d  = cur + PIDW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_OPEN;
      sel_q   <= '0;
      rr_q    <= '0;
      batch_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      batch_q <= batch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      hdr_q   <= '0;
      tmask_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
      pid_q   <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      isw_q   <= '0;
    end else if (fire) begin
      valid_q <= 1'b1;
      hdr_q   <= slot_hdr;
      tmask_q <= lane_tm;
      rs1_q   <= lane_rs1;
      rs2_q   <= lane_rs2;
      rs3_q   <= lane_rs3;
      pid_q   <= cur;
      sop_q   <= (state_q == ST_OPEN);
      eop_q   <= last;
      isw_q   <= sel;
    end else if (adv) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_hdr   = hdr_q;
  assign out_tmask = tmask_q;
  assign out_rs1   = rs1_q;
  assign out_rs2   = rs2_q;
  assign out_rs3   = rs3_q;
  assign out_pid   = pid_q;
  assign out_sop   = sop_q;
  assign out_eop   = eop_q;
  assign out_isw   = isw_q;

endmodule

// File: tb/tb_vx_dispatch_lane_packer.sv
// Bench for vx_dispatch_lane_packer: per-slot instruction queues feed the DUT and
// a packet-list reference model predicts every output packet and ready pulse.
module tb_vx_dispatch_lane_packer;

  localparam int IW = 4;
  localparam int NT = 4;
  localparam int NL = 2;
  localparam int XL = 32;
  localparam int HW = 64;
  localparam int NP = NT / NL;

  typedef struct packed {
    logic [HW-1:0]    hdr;
    logic [NT-1:0]    tm;
    logic [NT*XL-1:0] r1;
    logic [NT*XL-1:0] r2;
    logic [NT*XL-1:0] r3;
  } instr_t;

  logic                 clk;
  logic                 reset;
  logic [IW-1:0]        in_valid;
  logic [IW-1:0]        in_ready;
  logic [IW*HW-1:0]     in_hdr;
  logic [IW*NT-1:0]     in_tmask;
  logic [IW*NT*XL-1:0]  in_rs1, in_rs2, in_rs3;
  logic                 out_valid;
  logic                 out_ready;
  logic [HW-1:0]        out_hdr;
  logic [NL-1:0]        out_tmask;
  logic [NL*XL-1:0]     out_rs1, out_rs2, out_rs3;
  logic [0:0]           out_pid;
  logic                 out_sop, out_eop;
  logic [1:0]           out_isw;

  vx_dispatch_lane_packer #(
    .ISSUE_WIDTH(IW), .NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .HDRW(HW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr), .in_tmask(in_tmask),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr), .out_tmask(out_tmask),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop), .out_isw(out_isw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  instr_t slotq [IW][$];

  // reference model state
  bit               mv;
  logic [HW-1:0]    mh;
  logic [NL-1:0]    mt;
  logic [NL*XL-1:0] m1, m2, m3;
  int               mpid;
  bit               msop, meop;
  int               misw;
  bit               mlock;
  int               mslot;
  int               midx;
  int               mrr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push(input int s, input logic [3:0] tm, output instr_t it);
    it.hdr = {$urandom, $urandom};
    it.tm  = tm;
    it.r1  = r128();
    it.r2  = r128();
    it.r3  = r128();
    slotq[s].push_back(it);
  endtask

  task automatic drive();
    for (int s = 0; s < IW; s++) begin
      if (slotq[s].size() > 0) begin
        in_valid[s]            = 1'b1;
        in_hdr[s*HW +: HW]     = slotq[s][0].hdr;
        in_tmask[s*NT +: NT]   = slotq[s][0].tm;
        in_rs1[s*NT*XL +: NT*XL] = slotq[s][0].r1;
        in_rs2[s*NT*XL +: NT*XL] = slotq[s][0].r2;
        in_rs3[s*NT*XL +: NT*XL] = slotq[s][0].r3;
      end else begin
        in_valid[s]            = 1'b0;
        in_hdr[s*HW +: HW]     = '0;
        in_tmask[s*NT +: NT]   = '0;
        in_rs1[s*NT*XL +: NT*XL] = '0;
        in_rs2[s*NT*XL +: NT*XL] = '0;
        in_rs3[s*NT*XL +: NT*XL] = '0;
      end
    end
  endtask

  // One clock: drive inputs at negedge, predict and check in_ready, then check the registered packet.
  task automatic step(input bit ordy);
    int       slot;
    int       pids[$];
    int       k;
    int       pid;
    bit       fire, adv, sop, eop;
    instr_t   it;
    logic [IW-1:0] er;
    @(negedge clk);
    out_ready = ordy;
    drive();
    #1;
    fire = 0; er = '0; slot = -1; k = 0; pid = 0; sop = 0; eop = 0; it = '0;
    adv = !mv || ordy;
    if (reset && adv) begin
      if (mlock) slot = mslot;
      else
        for (int j = 0; j < IW; j++)
          if (slot < 0 && slotq[(mrr + j) % IW].size() > 0) slot = (mrr + j) % IW;
      if (slot >= 0) begin
        it = slotq[slot][0];
        for (int b = 0; b < NP; b++)
          if (it.tm[b*NL +: NL] != '0) pids.push_back(b);
        if (pids.size() == 0) pids.push_back(0);
        k    = mlock ? midx : 0;
        pid  = pids[k];
        sop  = (k == 0);
        eop  = (k == pids.size() - 1);
        fire = 1;
        if (eop) er[slot] = 1'b1;
      end
    end
    chk("in_ready", in_ready, er);
    @(posedge clk);
    #1;
    if (!reset) begin
      mv = 0; mh = '0; mt = '0; m1 = '0; m2 = '0; m3 = '0;
      mpid = 0; msop = 0; meop = 0; misw = 0;
      mlock = 0; midx = 0; mrr = 0;
    end else if (fire) begin
      mv = 1; mh = it.hdr; mt = it.tm[pid*NL +: NL];
      m1 = it.r1[pid*NL*XL +: NL*XL];
      m2 = it.r2[pid*NL*XL +: NL*XL];
      m3 = it.r3[pid*NL*XL +: NL*XL];
      mpid = pid; msop = sop; meop = eop; misw = slot;
      if (eop) begin
        void'(slotq[slot].pop_front());
        mlock = 0; midx = 0; mrr = (slot + 1) % IW;
      end else begin
        mlock = 1; mslot = slot; midx = k + 1;
      end
    end else if (adv) begin
      mv = 0;
    end
    chk("out_valid", out_valid, mv);
    if (mv || !reset) begin
      chk("out_hdr", out_hdr, mh);
      chk("out_tmask", out_tmask, mt);
      chk("out_rs1", out_rs1, m1);
      chk("out_rs2", out_rs2, m2);
      chk("out_rs3", out_rs3, m3);
      chk("out_pid", out_pid, mpid[0:0]);
      chk("out_sop", out_sop, msop);
      chk("out_eop", out_eop, meop);
      chk("out_isw", out_isw, misw[1:0]);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) step(1);
    reset = 1'b1;
  endtask

  initial begin
    instr_t a, b;
    int     exp_isw [6];
    int     n;
    bit     busy;
    reset = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_hdr = '0; in_tmask = '0; in_rs1 = '0; in_rs2 = '0; in_rs3 = '0;
    mv = 0; mlock = 0; midx = 0; mrr = 0; mslot = 0;
    mh = '0; mt = '0; m1 = '0; m2 = '0; m3 = '0; mpid = 0; msop = 0; meop = 0; misw = 0;

    // reset and idle
    do_reset(3);
    step(1); step(1);
    chk("idle_valid", out_valid, 1'b0);

    // full mask: two packets
    push(0, 4'b1111, a);
    step(1);
    chk("full_p0_pid", out_pid, 1'b0);
    chk("full_p0_sop", out_sop, 1'b1);
    chk("full_p0_eop", out_eop, 1'b0);
    chk("full_p0_tm", out_tmask, 2'b11);
    chk("full_p0_rs1", out_rs1, a.r1[63:0]);
    step(1);
    chk("full_p1_pid", out_pid, 1'b1);
    chk("full_p1_sop", out_sop, 1'b0);
    chk("full_p1_eop", out_eop, 1'b1);
    chk("full_p1_rs1", out_rs1, a.r1[127:64]);
    step(1);

    // upper-half mask, then empty mask
    push(1, 4'b1100, a);
    step(1);
    chk("hi_pid", out_pid, 1'b1);
    chk("hi_sop", out_sop, 1'b1);
    chk("hi_eop", out_eop, 1'b1);
    chk("hi_tm", out_tmask, 2'b11);
    push(2, 4'b0000, a);
    step(1);
    chk("zero_pid", out_pid, 1'b0);
    chk("zero_sop", out_sop, 1'b1);
    chk("zero_eop", out_eop, 1'b1);
    chk("zero_tm", out_tmask, 2'b00);
    step(1);

    // round-robin over slots 0,2,3
    do_reset(1);
    for (int r = 0; r < 2; r++) begin
      push(0, 4'b0011, a); push(2, 4'b0011, a); push(3, 4'b0011, a);
    end
    exp_isw = '{0, 2, 3, 0, 2, 3};
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("rr_isw", out_isw, exp_isw[i][1:0]);
    end
    step(1);

    // backpressure mid-instruction with a competing slot
    push(0, 4'b1111, a); push(1, 4'b1111, b);
    step(1);
    for (int i = 0; i < 3; i++) begin
      step(0);
      chk("stall_isw", out_isw, 2'd0);
      chk("stall_pid", out_pid, 1'b0);
    end
    step(1);
    chk("release_pid", out_pid, 1'b1);
    chk("release_isw", out_isw, 2'd0);
    step(1); step(1); step(1);

    // reset mid-instruction
    do_reset(1);
    push(1, 4'b1111, a);
    step(1);
    chk("prerst_isw", out_isw, 2'd1);
    do_reset(1);
    chk("rst_valid", out_valid, 1'b0);
    step(1);
    chk("resend_pid", out_pid, 1'b0);
    chk("resend_sop", out_sop, 1'b1);
    chk("resend_isw", out_isw, 2'd1);
    step(1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) < 45) begin
        n = $urandom_range(0, IW - 1);
        if (slotq[n].size() < 3) push(n, 4'($urandom_range(0, 15)), a);
      end
      step($urandom_range(0, 99) < 70);
    end
    n = 0;
    busy = 1;
    while (busy && n < 300) begin
      busy = mv;
      for (int s = 0; s < IW; s++) if (slotq[s].size() > 0) busy = 1;
      if (busy) step(1);
      n++;
    end
    chk("drain_timeout", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_dispatch_lane_packer.md
Name: vx_dispatch_lane_packer

Overview:
- Sits directly downstream of the dispatch stage. One instance per execution unit.
- Consumes the per-issue-slot dispatch streams for its unit and arbitrates round-robin among the ISSUE_WIDTH slots.
- Splits each selected instruction's NUM_THREADS-wide operands into NUM_LANES-wide packets. Packets whose thread-mask slice is zero are skipped.
- Packets are tagged with packet id, sop and eop, and feed the unit's lane-wide datapath through a registered output.

Parameters:
- ISSUE_WIDTH, 4, number of issue-slot input streams.
- NUM_THREADS, 4, threads per instruction.
- NUM_LANES, 2, execution lanes. NUM_THREADS % NUM_LANES == 0 is required.
- XLEN, 32, operand width.
- HDRW, 64, opaque header width (uuid/wis/PC/op/args/wb/rd/tid), passed through unchanged.

Derived values:
- NPKT = NUM_THREADS/NUM_LANES.
- PIDW = max(1, clog2(NPKT)).
- ISW = max(1, clog2(ISSUE_WIDTH)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset (block in reset while 0)
- in_valid  in  ISSUE_WIDTH  per-slot dispatch valid
- in_ready  out  ISSUE_WIDTH  per-slot dispatch ready
- in_hdr  in  ISSUE_WIDTH*HDRW  per-slot header
- in_tmask  in  ISSUE_WIDTH*NUM_THREADS  per-slot thread mask
- in_rs1/in_rs2/in_rs3  in  ISSUE_WIDTH*NUM_THREADS*XLEN  per-slot operands
- out_valid  out  1  packet valid
- out_ready  in  1  packet ready
- out_hdr  out  HDRW  header of current instruction
- out_tmask  out  NUM_LANES  lane mask slice
- out_rs1/out_rs2/out_rs3  out  NUM_LANES*XLEN  lane operand slices
- out_pid  out  PIDW  batch index of the packet
- out_sop  out  1  first packet of the instruction
- out_eop  out  1  last packet of the instruction
- out_isw  out  ISW  source issue slot

Behaviour:
- Reset (reset==0 at posedge):
  - out_valid=0; all out_* data=0; in_ready=0.
  - lock=0, batch_idx=0, rr_ptr=0.
  - Any in-flight instruction is dropped; the upstream holds it and re-presents it after reset.
- Output register advance: adv = !out_valid || out_ready. The output holds stable while out_valid && !out_ready.
- Selection:
  - Unlocked: sel = first slot with in_valid set, searching from rr_ptr upward with wrap.
  - Locked: sel = the latched slot.
  - Header, mask and operands are read from slot sel.
- Batch choice: cur = lowest batch b >= batch_idx whose tmask[b*NUM_LANES +: NUM_LANES] != 0.
- All-zero tmask: emit exactly one packet with pid=0, sop=eop=1, out_tmask=0.
- Firing (adv && a candidate exists) loads the output register with:
  - the header;
  - the lane slices of batch cur;
  - out_pid=cur;
  - out_sop = (no packet of this instruction emitted yet);
  - out_eop = (no nonzero batch above cur);
  - out_isw=sel.
- After a fire that is not the last packet: lock=1, latch sel, batch_idx=cur+1.
- After a fire that is the last packet:
  - in_ready[sel]=1 combinationally in the same cycle (this is the handshake);
  - lock=0, batch_idx=0, rr_ptr=(sel+1) mod ISSUE_WIDTH.
- in_ready is one-hot or zero and never asserts without a fire.
- Latency and throughput:
  - Input valid to out_valid is 1 cycle.
  - Sustained rate is one packet per cycle.
  - A single-packet instruction completes in 1 cycle; back-to-back instructions run with no bubble.
- Locked slot: while locked, other slots' valids are ignored. An upstream that drops in_valid of the locked slot is a protocol violation.
- Fairness: a continuously valid slot is served within ISSUE_WIDTH instructions.
- Simultaneous eop fire and a new valid elsewhere: the next instruction is chosen in the following cycle using the updated rr_ptr.

Test Plan:
- Reset then idle, in_valid=0 -> out_valid=0, in_ready=0, all outputs 0.
- Slot 0 valid, tmask=4'b1111, out_ready=1 -> 2 packets on consecutive cycles:
  - pid=0, sop=1, eop=0, tmask=2'b11, rs1 lanes = threads 0,1;
  - pid=1, sop=0, eop=1, rs1 lanes = threads 2,3;
  - in_ready[0] pulses in cycle 2 only.
- tmask=4'b1100 -> single packet pid=1, sop=1, eop=1, tmask=2'b11. tmask=4'b0000 -> single packet pid=0, sop=eop=1, tmask=0.
- Slots 0,2,3 continuously valid with tmask=4'b0011 -> out_isw order 0,2,3,0,2,... with one in_ready pulse per instruction.
- out_ready=0 for 3 cycles mid-instruction -> out_* held; slot stays locked and slot 1 valid is ignored; completes on release.
- reset=0 asserted after first packet of slot 1 -> next cycle out_valid=0, lock cleared; after release slot 1 is re-sent from pid=0 with sop=1.
